// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the 8-bit computer bus: default data width, default
// capture FIFO depth and the polarity of the bus load/enable strobes, so the
// bus driver and every bus register agree on what "asserted" means.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_WIDTH = 8;
  localparam int CAP_DEPTH = 4;

  // All bus strobes are active-low, 74LS-style.
  localparam logic STROBE_ACTIVE = 1'b0;

  function automatic logic strobe_asserted(input logic strobe_n);
    return strobe_n == STROBE_ACTIVE;
  endfunction

endpackage

// File: rtl/bus_load_register_if.sv
// ---------------------------------------------------------------------------
// bus_load_register_if
// Groups the bus-side and capture-side signals of bus_load_register.
//   bus_in       bus value to be loaded
//   ld_n         active-low load strobe
//   out          holding register contents
//   cap_data     capture FIFO head entry (valid while cap_valid)
//   cap_valid    capture FIFO non-empty
//   cap_ready    consumer accepts the head this cycle
//   cap_overflow sticky: a load was dropped because the FIFO was full
//   cap_count    current capture FIFO occupancy
// Modports: master (bus/monitor side driving the register), slave (register).
// ---------------------------------------------------------------------------
interface bus_load_register_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = CAP_DEPTH
);

  logic [WIDTH-1:0]        bus_in;
  logic                    ld_n;
  logic [WIDTH-1:0]        out;
  logic [WIDTH-1:0]        cap_data;
  logic                    cap_valid;
  logic                    cap_ready;
  logic                    cap_overflow;
  logic [$clog2(DEPTH):0]  cap_count;

  modport master (
    output bus_in, ld_n, cap_ready,
    input  out, cap_data, cap_valid, cap_overflow, cap_count
  );

  modport slave (
    input  bus_in, ld_n, cap_ready,
    output out, cap_data, cap_valid, cap_overflow, cap_count
  );

endinterface

// File: rtl/bus_capture_fifo.sv
// ---------------------------------------------------------------------------
// bus_capture_fifo
// Small synchronous FIFO with a registered head output, used as a debug tap
// on bus traffic. A push into a full FIFO is accepted only if a pop happens in
// the same cycle; a pop on an empty FIFO is ignored.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail this cycle
//   push_data    data to write
//   pop          remove the head entry this cycle
//   head_data    registered head entry (meaningful while !empty)
//   full, empty  occupancy flags derived from count
//   count        occupancy, 0..DEPTH
// DEPTH must be a power of 2 and at least 2 (pointers wrap naturally).
// ---------------------------------------------------------------------------
module bus_capture_fifo
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = CAP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Accept/refuse decisions and the next head value. A pop frees the slot a
  // same-cycle push needs, so a full FIFO still takes the push. The head
  // register is loaded straight from push_data when the new entry becomes
  // the head (FIFO empty, or its only entry is leaving), otherwise from
  // storage at the advanced read pointer.
  always_comb begin
    push_ok     = push && (!full || pop);
    pop_ok      = pop && !empty;
    rd_ptr_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count - CW'(1);
    end

    head_next = head_data;
    if (push_ok && (empty || (pop_ok && count == CW'(1)))) begin
      head_next = push_data;
    end else if (pop_ok) begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      head_data <= head_next;
    end
  end

endmodule

// File: rtl/bus_load_register.sv
// ---------------------------------------------------------------------------
// bus_load_register
// Receive side of the shared bus: a 74LS173-style holding register loaded
// from the bus while the active-low load strobe is asserted at a clock edge.
// Every accepted load is also pushed into a capture FIFO that a debug
// monitor drains through a valid/ready handshake; loads that find the FIFO
// full are dropped from the capture (the register still updates) and set a
// sticky overflow flag.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bus_load_register_if.slave: bus_in, ld_n, out, cap_data,
//          cap_valid, cap_ready, cap_overflow, cap_count
// Build option BUS_LOAD_EDGE_EN: when defined, only the first cycle of a
// multi-cycle ld_n strobe counts as a load; otherwise every low cycle does.
// ---------------------------------------------------------------------------
module bus_load_register
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = CAP_DEPTH
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_load_register_if.slave  bus
);

  logic [WIDTH-1:0] out_q;
  logic             overflow_q;
  logic             load_event;
  logic             fifo_full;
  logic             fifo_empty;

`ifdef BUS_LOAD_EDGE_EN
  // Previous-edge strobe sample; resetting it to idle makes a strobe that is
  // already low at reset release count as a fresh load.
  logic ld_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_n_q <= ~STROBE_ACTIVE;
    end else begin
      ld_n_q <= bus.ld_n;
    end
  end

  assign load_event = strobe_asserted(bus.ld_n) && !strobe_asserted(ld_n_q);
`else
  assign load_event = strobe_asserted(bus.ld_n);
`endif

  // Holding register and sticky overflow. A load is dropped from the capture
  // only when the FIFO is full and nothing is popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (load_event) begin
        out_q <= bus.bus_in;
      end
      if (load_event && fifo_full && !bus.cap_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  bus_capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_capture_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (load_event),
    .push_data (bus.bus_in),
    .pop       (bus.cap_ready),
    .head_data (bus.cap_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (bus.cap_count)
  );

  assign bus.out          = out_q;
  assign bus.cap_valid    = !fifo_empty;
  assign bus.cap_overflow = overflow_q;

endmodule

// File: tb/tb_bus_load_register.sv
// ---------------------------------------------------------------------------
// tb_bus_load_register
// Self-checking bench for bus_load_register (WIDTH=8, DEPTH=4). A behavioural
// model tracks the expected register value, overflow flag and a queue of
// expected capture entries; each test task compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_bus_load_register;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_out;
  logic             exp_ovf;
  logic             prev_ld;

  bus_load_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

  bus_load_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock cycle and advance the model; outputs settle #1 after the edge.
  task automatic step(input logic [WIDTH-1:0] b, input logic l, input logic r);
    logic load;
    logic pop;
    logic was_full;
    @(negedge clk);
    bif.bus_in    = b;
    bif.ld_n      = l;
    bif.cap_ready = r;
`ifdef BUS_LOAD_EDGE_EN
    load = (l == 1'b0) && (prev_ld == 1'b1);
`else
    load = (l == 1'b0);
`endif
    was_full = (exp_q.size() == DEPTH);
    pop      = r && (exp_q.size() != 0);
    if (pop) void'(exp_q.pop_front());
    if (load) begin
      exp_out = b;
      if (!was_full || pop) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
    prev_ld = l;
    @(posedge clk);
    #1;
  endtask

  // Load one value; in edge mode a release cycle follows so the next load is a new edge.
  task automatic load_one(input logic [WIDTH-1:0] b);
    step(b, 1'b0, 1'b0);
`ifdef BUS_LOAD_EDGE_EN
    step(b, 1'b1, 1'b0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif.ld_n      = 1'b1;
    bif.cap_ready = 1'b0;
    bif.bus_in    = '0;
    rst_n         = 1'b0;
    exp_q.delete();
    exp_out = '0;
    exp_ovf = 1'b0;
    prev_ld = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bif.ld_n      = 1'b1;
    bif.cap_ready = 1'b0;
    bif.bus_in    = '0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_out = '0;
    exp_ovf = 1'b0;
    prev_ld = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bif.out !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_out got=%h want=00", bif.out);
    end
    checks++;
    if (bif.cap_valid !== 1'b0 || bif.cap_count !== 3'd0) begin
      failures++; $display("[TB] FAIL reset_fifo got valid=%b count=%0d want valid=0 count=0", bif.cap_valid, bif.cap_count);
    end
    checks++;
    if (bif.cap_data !== 8'h00 || bif.cap_overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_data_ovf got data=%h ovf=%b want data=00 ovf=0", bif.cap_data, bif.cap_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    step(8'hA5, 1'b0, 1'b0);
    checks++;
    if (bif.out !== 8'hA5) begin
      failures++; $display("[TB] FAIL single_out got=%h want=a5", bif.out);
    end
    checks++;
    if (bif.cap_valid !== 1'b1 || bif.cap_data !== 8'hA5) begin
      failures++; $display("[TB] FAIL single_cap got valid=%b data=%h want valid=1 data=a5", bif.cap_valid, bif.cap_data);
    end
    checks++;
    if (bif.cap_count !== 3'd1) begin
      failures++; $display("[TB] FAIL single_count got=%0d want=1", bif.cap_count);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      step((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1, 1'b0);
      checks++;
      if (bif.out !== exp_out || bif.cap_count !== 3'(exp_q.size())) begin
        failures++; $display("[TB] FAIL hold_%0d got out=%h count=%0d want out=%h count=%0d", i, bif.out, bif.cap_count, exp_out, exp_q.size());
      end
    end
    checks++;
    if (bif.out !== 8'hA5) begin
      failures++; $display("[TB] FAIL hold_value got=%h want=a5", bif.out);
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (bif.cap_data !== exp_q[0]) begin
      failures++; $display("[TB] FAIL pre_drain got=%h want=%h", bif.cap_data, exp_q[0]);
    end
    step(8'h00, 1'b1, 1'b1);
    for (int v = 1; v <= 5; v++) load_one(8'(v));
    checks++;
    if (bif.cap_count !== 3'd4 || bif.cap_overflow !== 1'b1 || exp_ovf !== 1'b1) begin
      failures++; $display("[TB] FAIL ovf_state got count=%0d ovf=%b want count=4 ovf=1", bif.cap_count, bif.cap_overflow);
    end
    checks++;
    if (bif.out !== 8'h05) begin
      failures++; $display("[TB] FAIL ovf_out got=%h want=05", bif.out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.cap_valid !== 1'b1 || bif.cap_data !== 8'(i + 1) || bif.cap_data !== exp_q[0]) begin
        failures++; $display("[TB] FAIL drain_%0d got valid=%b data=%h want valid=1 data=%h", i, bif.cap_valid, bif.cap_data, 8'(i + 1));
      end
      step(8'h00, 1'b1, 1'b1);
    end
    checks++;
    if (bif.cap_valid !== 1'b0 || bif.cap_count !== 3'd0) begin
      failures++; $display("[TB] FAIL drain_empty got valid=%b count=%0d want valid=0 count=0", bif.cap_valid, bif.cap_count);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int v = 0; v < 4; v++) load_one(8'h10 + 8'(v));
    checks++;
    if (bif.cap_count !== 3'd4 || bif.cap_data !== 8'h10) begin
      failures++; $display("[TB] FAIL refill got count=%0d data=%h want count=4 data=10", bif.cap_count, bif.cap_data);
    end
    step(8'h77, 1'b0, 1'b1);
    checks++;
    if (bif.cap_overflow !== 1'b0 || bif.cap_count !== 3'd4) begin
      failures++; $display("[TB] FAIL full_pushpop got ovf=%b count=%0d want ovf=0 count=4", bif.cap_overflow, bif.cap_count);
    end
    step(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.cap_valid !== 1'b1 || bif.cap_data !== exp_q[0]) begin
        failures++; $display("[TB] FAIL order_%0d got valid=%b data=%h want valid=1 data=%h", i, bif.cap_valid, bif.cap_data, exp_q[0]);
      end
      if (i == 3) begin
        checks++;
        if (bif.cap_data !== 8'h77) begin
          failures++; $display("[TB] FAIL last_entry got=%h want=77", bif.cap_data);
        end
      end
      step(8'h00, 1'b1, 1'b1);
    end
    checks++;
    if (bif.cap_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL order_empty got valid=%b want=0", bif.cap_valid);
    end
  endtask

  task automatic test_strobe();
    logic [3:0] want;
`ifdef BUS_LOAD_EDGE_EN
    want = 4'd1;
`else
    want = 4'd3;
`endif
    for (int i = 0; i < 3; i++) step(8'h3C, 1'b0, 1'b0);
    step(8'h3C, 1'b1, 1'b0);
    checks++;
    if (bif.cap_count !== want[2:0] || bif.cap_count !== 3'(exp_q.size())) begin
      failures++; $display("[TB] FAIL strobe_count got=%0d want=%0d", bif.cap_count, want);
    end
    checks++;
    if (bif.out !== 8'h3C) begin
      failures++; $display("[TB] FAIL strobe_out got=%h want=3c", bif.out);
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() != 0) begin
        checks++;
        if (bif.cap_data !== exp_q[0]) begin
          failures++; $display("[TB] FAIL strobe_drain_%0d got=%h want=%h", i, bif.cap_data, exp_q[0]);
        end
        step(8'h00, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    load_one(8'h10);
    load_one(8'h11);
    load_one(8'h12);
    load_one(8'h13);
    load_one(8'h42);
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    checks++;
    if (bif.cap_count !== 3'd2 || bif.out !== 8'h42 || bif.cap_overflow !== 1'b1) begin
      failures++; $display("[TB] FAIL pre_burst got count=%0d out=%h ovf=%b want count=2 out=42 ovf=1", bif.cap_count, bif.out, bif.cap_overflow);
    end
    checks++;
    if (bif.cap_data !== 8'h12) begin
      failures++; $display("[TB] FAIL pre_burst_head got=%h want=12", bif.cap_data);
    end
    @(negedge clk);
    bif.bus_in    = 8'h43;
    bif.ld_n      = 1'b0;
    bif.cap_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bif.out !== 8'h00 || bif.cap_valid !== 1'b0 || bif.cap_overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset got out=%h valid=%b ovf=%b want out=00 valid=0 ovf=0", bif.out, bif.cap_valid, bif.cap_overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bif.out !== 8'h00 || bif.cap_count !== 3'd0) begin
      failures++; $display("[TB] FAIL reset_held got out=%h count=%0d want out=00 count=0", bif.out, bif.cap_count);
    end
    exp_q.delete();
    exp_out = '0;
    exp_ovf = 1'b0;
    prev_ld = 1'b1;
    @(negedge clk);
    bif.ld_n = 1'b1;
    rst_n    = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_load();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_strobe();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_load_register.md
Name: bus_load_register

Overview:
- Receive side of the shared 8-bit bus. This is the counterpart of the active-low-enabled bus driver.
- Latches the bus into a holding register whenever its active-low load strobe is asserted at a clock edge, which is the 74LS173-style "load from bus" function.
- Also pushes every accepted load into a small FIFO. A downstream monitor (display/UART debug path) drains it with a valid/ready handshake, so bus traffic can be observed without stalling the computer.

Parameters:
- WIDTH, 8, bus and register data width.
- DEPTH, 4, capture FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bus_in  input  WIDTH  bus value to be loaded.
- ld_n  input  1  active-low load strobe.
- out  output  WIDTH  holding register contents, driven continuously.
- cap_data  output  WIDTH  FIFO head entry; valid only while cap_valid=1.
- cap_valid  output  1  FIFO non-empty.
- cap_ready  input  1  consumer accepts head this cycle.
- cap_overflow  output  1  sticky: a load was dropped because the FIFO was full.
- cap_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - out=0, FIFO empty, cap_valid=0, cap_data=0, cap_count=0, cap_overflow=0.
  - Reset overrides everything, including a load in progress mid-burst.
- Load event: ld_n==0 sampled at posedge clk (see LOAD_EDGE_EN for the alternative).
  - out <= bus_in at that edge. Visible one cycle after the edge where ld_n is sampled low.
  - ld_n==1 means out holds its value.
  - No combinational path from bus_in to out.
- Capture push: each load event also writes bus_in into the FIFO tail.
  - If the FIFO is full and no pop occurs that cycle, the push is dropped, cap_overflow <= 1, and out is still updated.
- Capture pop: cap_valid && cap_ready at posedge removes the head entry.
  - cap_data is the registered head; it shows the next entry the following cycle.
  - cap_ready while empty has no effect.
- Simultaneous push and pop:
  - Both are accepted and cap_count is unchanged. This holds when full: the pop frees the slot, so no overflow.
  - When empty, the push is accepted and no pop occurs. First-word latency is 1 cycle from the load edge to cap_valid=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from cap_count, which ranges 0..DEPTH.
- cap_overflow clears only on reset.
- FIFO order is strict: entries come out in load order.

Optional Feature:
- Macro: BUS_LOAD_EDGE_EN.
- Defined:
  - A load event is ld_n sampled low on an edge where it was sampled high on the previous edge (ld_n_q register; resets to 1).
  - A multi-cycle strobe loads and captures exactly once, on its first cycle.
  - If ld_n is low at reset release, that first cycle counts as a load.
- Undefined:
  - Every edge with ld_n==0 is a load event. A 3-cycle strobe loads out three times and pushes three FIFO entries.

Decomposition:
- Package bus_pkg holds:
  - BUS_WIDTH=8 and the default capture depth.
  - An active-low strobe constant (STROBE_ACTIVE=1'b0), shared with the bus driver and other bus registers.
- Sub-module bus_capture_fifo:
  - Synchronous FIFO with push/pop/full/empty/count, storage, pointers and registered head.
  - Reusable for other debug taps.
- The top level keeps the holding register, load-event detection and the overflow flag.

Test Plan:
- Reset then ld_n=0 for one cycle with bus_in=8'hA5 -> out=8'hA5 one cycle later; cap_valid=1, cap_data=8'hA5, cap_count=1.
- ld_n=1 while bus_in toggles 8'h00/8'hFF for 5 cycles -> out holds its previous value; cap_count unchanged.
- cap_ready=0; loads 8'h01..8'h05 on consecutive cycles, DEPTH=4 -> cap_count=4, cap_overflow=1, out=8'h05. Then drain with cap_ready=1 -> cap_data reads 01,02,03,04 and cap_valid drops.
- FIFO full; load 8'h77 and pop in the same cycle -> no overflow, cap_count stays 4, and 8'h77 emerges last.
- ld_n low for 3 cycles with bus_in=8'h3C -> cap_count=3 without BUS_LOAD_EDGE_EN; cap_count=1 with it.
- Mid-burst (FIFO holding 2 entries, out=8'h42), assert rst_n=0 between clock edges -> out=0, cap_valid=0, cap_overflow=0 immediately, before the next clock edge.
